// File: rtl/pci_arbiter.sv
// -----------------------------------------------------------------------------
// pci_arbiter
//
// Central bus arbiter for the PCI target subsystem. It grants the shared
// AddressData/CBE/Frame/Irdy bus to one of NUM_MASTERS initiators. Selection is
// round-robin. A granted master that never starts is timed out. At least one
// all-ones Gnt cycle separates successive owners. Bus occupancy is tracked by
// observing Frame and Irdy.
//
// Parameters
//   NUM_MASTERS  number of requesting initiators (2..8)
//   GNT_TIMEOUT  idle-bus cycles a granted master may take to assert Frame (>=2)
//
// Ports
//   Clock    in   bus clock, rising-edge active
//   RST      in   synchronous active-high reset
//   Req      in   [NUM_MASTERS]  per-master request, active low
//   Frame    in   bus Frame, active low
//   Irdy     in   bus Irdy, active low
//   Gnt      out  [NUM_MASTERS]  per-master grant, active low, registered
//   Owner    out  [clog2(NUM_MASTERS)]  current or last granted master
//   BusBusy  out  high while a transaction is in progress (state BUSY)
//
// Build option
//   PCI_ARB_PARK_EN  when defined, the bus is parked on the last owner while
//                    nobody requests it
// -----------------------------------------------------------------------------
module pci_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic                           Clock,
    input  logic                           RST,
    input  logic [NUM_MASTERS-1:0]         Req,
    input  logic                           Frame,
    input  logic                           Irdy,
    output logic [NUM_MASTERS-1:0]         Gnt,
    output logic [$clog2(NUM_MASTERS)-1:0] Owner,
    output logic                           BusBusy
);

    localparam int OW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(GNT_TIMEOUT);

    localparam logic [NUM_MASTERS-1:0] GNT_NONE  = {NUM_MASTERS{1'b1}};
    localparam logic [CW-1:0]          CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]          CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]          CNT_LAST  = CW'(GNT_TIMEOUT - 1);
    localparam logic [OW-1:0]          OWN_ZERO  = {OW{1'b0}};
    localparam logic [OW-1:0]          OWN_RESET = OW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   gnt_q, gnt_d;
    logic [OW-1:0]            owner_q, owner_d;
    logic [OW-1:0]            last_q, last_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     busy_q, busy_d;

    logic                     bus_idle_s;
    logic                     req_any_s;
    logic                     others_req_s;
    logic [OW-1:0]            winner_s;
`ifdef PCI_ARB_PARK_EN
    logic                     parked_s;
`endif

    // Active-low grant vector with only the given master's bit low.
    function automatic logic [NUM_MASTERS-1:0] gnt_of(input logic [OW-1:0] idx);
        logic [NUM_MASTERS-1:0] g;
        g      = GNT_NONE;
        g[idx] = 1'b0;
        return g;
    endfunction

    // Round-robin pick: first low Req bit starting just after the last owner.
    // With no request pending the result is unused, so it falls back to last.
    function automatic logic [OW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req_n,
                                              input logic [OW-1:0]          last);
        logic [OW-1:0] pick;
        logic [OW-1:0] sel;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = (int'(last) + i) % NUM_MASTERS;
            sel = OW'(idx);
            if (!found && !req_n[sel]) begin
                pick  = sel;
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

    // Bus status and arbitration helpers derived from the sampled inputs.
    always_comb begin
        bus_idle_s   = Frame & Irdy;
        req_any_s    = ~&Req;
        // gnt_of(owner) has a 1 everywhere except the owner, so it masks the owner out.
        others_req_s = |(~Req & gnt_of(owner_q));
        winner_s     = rr_pick(Req, last_q);
`ifdef PCI_ARB_PARK_EN
        parked_s     = (state_q == ST_IDLE) && (gnt_q != GNT_NONE);
`endif
    end

    // Next-state and registered-output decode for the arbitration FSM.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
`ifdef PCI_ARB_PARK_EN
                if (parked_s && !Frame) begin
                    // Parked master starts directly, no dead cycle.
                    state_d = ST_BUSY;
                    gnt_d   = gnt_q;
                end else if (parked_s && req_any_s) begin
                    // Drop the park and arbitrate after a dead cycle.
                    state_d = ST_RELEASE;
                    gnt_d   = GNT_NONE;
                end else if (req_any_s) begin
                    state_d = ST_GRANT;
                    owner_d = winner_s;
                    gnt_d   = gnt_of(winner_s);
                    cnt_d   = CNT_ZERO;
                end else begin
                    owner_d = last_q;
                    gnt_d   = gnt_of(last_q);
                end
`else
                if (req_any_s) begin
                    state_d = ST_GRANT;
                    owner_d = winner_s;
                    gnt_d   = gnt_of(winner_s);
                    cnt_d   = CNT_ZERO;
                end else begin
                    gnt_d   = GNT_NONE;
                end
`endif
            end

            ST_GRANT: begin
                // Any exit from GRANT consumes the owner's turn.
                if (!Frame) begin
                    state_d = ST_BUSY;
                    gnt_d   = gnt_q;
                    last_d  = owner_q;
                end else if (Req[owner_q]) begin
                    state_d = ST_RELEASE;
                    gnt_d   = GNT_NONE;
                    last_d  = owner_q;
                end else if (bus_idle_s && (cnt_q == CNT_LAST)) begin
                    state_d = ST_RELEASE;
                    gnt_d   = GNT_NONE;
                    last_d  = owner_q;
                end else if (bus_idle_s) begin
                    cnt_d   = cnt_q + CNT_ONE;
                end else begin
                    // A previous owner is still finishing; the timeout waits.
                    cnt_d   = cnt_q;
                end
            end

            ST_BUSY: begin
                if (bus_idle_s) begin
                    state_d = ST_RELEASE;
                    gnt_d   = GNT_NONE;
                end else if (others_req_s) begin
                    // Preempt: remove the grant, the master completes its cycle.
                    gnt_d   = GNT_NONE;
                end else begin
                    gnt_d   = gnt_q;
                end
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
                gnt_d   = GNT_NONE;
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase

        busy_d = (state_d == ST_BUSY);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (RST) begin
            state_q <= ST_IDLE;
            gnt_q   <= GNT_NONE;
            owner_q <= OWN_ZERO;
            last_q  <= OWN_RESET;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign Gnt     = gnt_q;
    assign Owner   = owner_q;
    assign BusBusy = busy_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pci_arbiter
//
// Directed bench for pci_arbiter (NUM_MASTERS=4, GNT_TIMEOUT=16, no parking).
// Each stimulus step drives inputs for the next rising edge and queues the
// hand-computed Gnt/Owner/BusBusy expected after that edge. A separate monitor
// samples the outputs 1 time unit after each edge and compares.
// -----------------------------------------------------------------------------
module tb_pci_arbiter;

    typedef struct {
        int         edge_no;
        string      name;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
    } exp_t;

    logic       Clock = 1'b0;
    logic       RST;
    logic [3:0] Req;
    logic       Frame;
    logic       Irdy;
    logic [3:0] Gnt;
    logic [1:0] Owner;
    logic       BusBusy;

    exp_t sb_q[$];
    int   edge_n = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;

    pci_arbiter #(
        .NUM_MASTERS(4),
        .GNT_TIMEOUT(16)
    ) dut (
        .Clock  (Clock),
        .RST    (RST),
        .Req    (Req),
        .Frame  (Frame),
        .Irdy   (Irdy),
        .Gnt    (Gnt),
        .Owner  (Owner),
        .BusBusy(BusBusy)
    );

    always #5 Clock = ~Clock;

    // Monitor: count edges and compare queued expectations due at this edge.
    initial begin
        forever begin
            @(posedge Clock);
            #1;
            edge_n++;
            while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_n) begin
                exp_t e;
                e = sb_q.pop_front();
                n_vec++;
                if (e.edge_no < edge_n) begin
                    n_bad++;
                    $display("FAIL %s: expectation for edge %0d not checked (now edge %0d)",
                             e.name, e.edge_no, edge_n);
                end else if (Gnt !== e.gnt || Owner !== e.owner || BusBusy !== e.busy) begin
                    n_bad++;
                    $display("FAIL %s @edge %0d: got Gnt=%b Owner=%0d BusBusy=%b, expected Gnt=%b Owner=%0d BusBusy=%b",
                             e.name, edge_n, Gnt, Owner, BusBusy, e.gnt, e.owner, e.busy);
                end
            end
        end
    end

    // One bus cycle: drive inputs for the next edge and queue the expected outputs.
    task automatic cyc(input logic rst, input logic [3:0] req, input logic fr, input logic ir,
                       input string nm, input logic [3:0] g, input logic [1:0] o, input logic b);
        exp_t e;
        @(posedge Clock);
        #2;
        RST   = rst;
        Req   = req;
        Frame = fr;
        Irdy  = ir;
        e.edge_no = edge_n + 1;
        e.name    = nm;
        e.gnt     = g;
        e.owner   = o;
        e.busy    = b;
        sb_q.push_back(e);
    endtask

    // Transaction by granted master m with all Req held low; ends with m_next granted.
    task automatic rr_xact(input int m, input int m_next);
        logic [3:0] gm;
        logic [3:0] gn;
        logic [1:0] om;
        logic [1:0] on;
        gm = 4'b1111; gm[m] = 1'b0;
        gn = 4'b1111; gn[m_next] = 1'b0;
        om = 2'(m);
        on = 2'(m_next);
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, "rr_addr",    gm,      om, 1'b1);
        cyc(1'b0, 4'b0000, 1'b0, 1'b0, "rr_preempt", 4'b1111, om, 1'b1);
        cyc(1'b0, 4'b0000, 1'b0, 1'b0, "rr_data",    4'b1111, om, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1, 1'b0, "rr_last",    4'b1111, om, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1, 1'b1, "rr_release", 4'b1111, om, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 1'b1, "rr_idle",    4'b1111, om, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 1'b1, "rr_grant",   gn,      on, 1'b0);
    endtask

    // Stimulus sequence.
    initial begin
        RST   = 1'b1;
        Req   = 4'b0000;
        Frame = 1'b1;
        Irdy  = 1'b1;

        // Reset with requests pending, then first grant goes to master 0.
        cyc(1'b1, 4'b0000, 1'b1, 1'b1, "reset1",      4'b1111, 2'd0, 1'b0);
        cyc(1'b1, 4'b0000, 1'b1, 1'b1, "reset2",      4'b1111, 2'd0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 1'b1, "first_grant", 4'b1110, 2'd0, 1'b0);

        // Round-robin order 0,1,2,3,0.
        rr_xact(0, 1);
        rr_xact(1, 2);
        rr_xact(2, 3);
        rr_xact(3, 0);

        // Withdrawal by master 0 still consumes its turn: next winner is 1.
        cyc(1'b0, 4'b1111, 1'b1, 1'b1, "wd_release", 4'b1111, 2'd0, 1'b0);
        cyc(1'b0, 4'b1111, 1'b1, 1'b1, "wd_idle",    4'b1111, 2'd0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 1'b1, "wd_next",    4'b1101, 2'd1, 1'b0);

        // Master 1 alone keeps its grant, then Req[3] preempts.
        cyc(1'b0, 4'b1101, 1'b0, 1'b1, "pre_addr",    4'b1101, 2'd1, 1'b1);
        cyc(1'b0, 4'b1101, 1'b0, 1'b0, "pre_hold",    4'b1101, 2'd1, 1'b1);
        cyc(1'b0, 4'b0101, 1'b0, 1'b0, "pre_drop",    4'b1111, 2'd1, 1'b1);
        cyc(1'b0, 4'b0101, 1'b1, 1'b0, "pre_finish",  4'b1111, 2'd1, 1'b1);
        cyc(1'b0, 4'b0101, 1'b1, 1'b1, "pre_release", 4'b1111, 2'd1, 1'b0);
        cyc(1'b0, 4'b0101, 1'b1, 1'b1, "pre_idle",    4'b1111, 2'd1, 1'b0);
        cyc(1'b0, 4'b0101, 1'b1, 1'b1, "pre_grant3",  4'b0111, 2'd3, 1'b0);

        // Master 3 withdraws; master 2 alone is granted and times out.
        cyc(1'b0, 4'b1011, 1'b1, 1'b1, "to_wd3",   4'b1111, 2'd3, 1'b0);
        cyc(1'b0, 4'b1011, 1'b1, 1'b1, "to_idle",  4'b1111, 2'd3, 1'b0);
        cyc(1'b0, 4'b1011, 1'b1, 1'b1, "to_grant", 4'b1011, 2'd2, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            cyc(1'b0, 4'b1011, 1'b1, 1'b1, "to_wait", 4'b1011, 2'd2, 1'b0);
        end
        cyc(1'b0, 4'b1011, 1'b1, 1'b1, "to_expire", 4'b1111, 2'd2, 1'b0);
        cyc(1'b0, 4'b1011, 1'b1, 1'b1, "to_idle2",  4'b1111, 2'd2, 1'b0);
        cyc(1'b0, 4'b1011, 1'b1, 1'b1, "to_regrant", 4'b1011, 2'd2, 1'b0);

        // Counter holds while the bus is busy (Irdy low), then 16 idle cycles.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 4'b1011, 1'b1, 1'b0, "to_busy_hold", 4'b1011, 2'd2, 1'b0);
        end
        for (int i = 1; i <= 15; i++) begin
            cyc(1'b0, 4'b1011, 1'b1, 1'b1, "to_wait2", 4'b1011, 2'd2, 1'b0);
        end
        cyc(1'b0, 4'b1011, 1'b1, 1'b1, "to_expire2", 4'b1111, 2'd2, 1'b0);

        // Frame from an unknown master in IDLE is ignored.
        cyc(1'b0, 4'b1111, 1'b0, 1'b0, "stray_frame1", 4'b1111, 2'd2, 1'b0);
        cyc(1'b0, 4'b1111, 1'b0, 1'b0, "stray_frame2", 4'b1111, 2'd2, 1'b0);

        // Reset in the middle of a transaction.
        cyc(1'b0, 4'b0111, 1'b1, 1'b1, "mid_grant3", 4'b0111, 2'd3, 1'b0);
        cyc(1'b0, 4'b0111, 1'b0, 1'b0, "mid_busy",   4'b0111, 2'd3, 1'b1);
        cyc(1'b1, 4'b0111, 1'b0, 1'b0, "mid_reset",  4'b1111, 2'd0, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1, 1'b1, "post_reset", 4'b1110, 2'd0, 1'b0);

        repeat (2) @(posedge Clock);
        #3;
        if (sb_q.size() != 0) begin
            n_vec += sb_q.size();
            n_bad += sb_q.size();
            $display("FAIL pending: %0d expectations never checked, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
